// File: rtl/muldiv_seq.sv
// muldiv_seq -- sequential 32x32 multiply / divide unit with HI/LO result
// registers, one iteration per clock (32 iterations plus one sign-fix cycle).
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   rst       : asynchronous active-low reset
//   start     : request a new operation (accepted in IDLE or DONE)
//   op        : 00 MULTU, 01 MULT, 10 DIVU, 11 DIV (sampled with start)
//   a, b      : operands (multiplicand/dividend, multiplier/divisor)
//   hilo_we   : direct HI/LO write (mthi/mtlo), accepted only when idle
//   hilo_sel  : direct-write target, 1 = HI, 0 = LO
//   wdata     : direct-write data
//   busy      : operation in progress (CALC or FIX)
//   done      : one-cycle pulse, HI/LO hold a new result
//   hi, lo    : HI/LO registers
//
// state | meaning
// IDLE  | waiting for start or a direct HI/LO write
// CALC  | one shift-add / restoring-divide iteration per cycle on magnitudes
// FIX   | sign correction, HI/LO written at the exit edge
// DONE  | result valid for one cycle; start here chains a new operation
module muldiv_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hilo_we,
    input  logic        hilo_sel,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        op_div_q, op_div_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_a_q, neg_a_d;
    logic [31:0] mag_a_q, mag_a_d;
    logic [31:0] mag_b_q, mag_b_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // Operand conditioning at the accept edge (signed ops use magnitudes).
    logic        a_neg_in, b_neg_in;
    logic [31:0] mag_a_in, mag_b_in;

    assign a_neg_in = op[0] & a[31];
    assign b_neg_in = op[0] & b[31];
    assign mag_a_in = a_neg_in ? (32'd0 - a) : a;
    assign mag_b_in = b_neg_in ? (32'd0 - b) : b;

    // Multiply step: acc = {partial product, remaining multiplier bits}.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;

    assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_a_q} : 33'd0);
    assign mul_next = {mul_sum, acc_q[31:1]};

    // Restoring divide step: acc = {partial remainder, dividend/quotient bits}.
    logic [32:0] div_shift;
    logic [33:0] div_diff;
    logic        div_ge;
    logic [31:0] div_rem;
    logic [63:0] div_next;

    assign div_shift = acc_q[63:31];
    assign div_diff  = {1'b0, div_shift} - {2'b00, mag_b_q};
    assign div_ge    = ~div_diff[33];
    assign div_rem   = div_ge ? div_diff[31:0] : div_shift[31:0];
    assign div_next  = {div_rem, acc_q[30:0], div_ge};

    // Sign-corrected results presented in FIX.
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    assign prod_fix = neg_res_q ? (64'd0 - acc_q) : acc_q;
    assign rem_fix  = neg_a_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
    // A zero divisor leaves all quotient bits set; report that raw pattern
    // rather than letting sign correction turn it into 1.
    assign quo_fix  = (mag_b_q == 32'd0) ? 32'hFFFF_FFFF :
                      (neg_res_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0]);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_div_d  = op_div_q;
        neg_res_d = neg_res_q;
        neg_a_d   = neg_a_q;
        mag_a_d   = mag_a_q;
        mag_b_d   = mag_b_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_CALC;
                    cnt_d     = 5'd0;
                    op_div_d  = op[1];
                    neg_res_d = a_neg_in ^ b_neg_in;
                    neg_a_d   = a_neg_in;
                    mag_a_d   = mag_a_in;
                    mag_b_d   = mag_b_in;
                    acc_d     = op[1] ? {32'd0, mag_a_in} : {32'd0, mag_b_in};
                end else begin
                    state_d = S_IDLE;
                    if (hilo_we) begin
                        if (hilo_sel) hi_d = wdata;
                        else          lo_d = wdata;
                    end
                end
            end
            S_CALC: begin
                acc_d = op_div_q ? div_next : mul_next;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_DONE;
                if (op_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 5'd0;
            op_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_a_q   <= 1'b0;
            mag_a_q   <= 32'd0;
            mag_b_q   <= 32'd0;
            acc_q     <= 64'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_div_q  <= op_div_d;
            neg_res_q <= neg_res_d;
            neg_a_q   <= neg_a_d;
            mag_a_q   <= mag_a_d;
            mag_b_q   <= mag_b_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = (state_q == S_CALC) || (state_q == S_FIX);
    assign done = (state_q == S_DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Testbench for muldiv_seq: a cycle-level behavioural model computes the
// results with plain 64-bit arithmetic and a latency countdown; a compare
// process checks busy/done/hi/lo every cycle, and directed scenarios add
// hand-computed literal expectations.
module tb_muldiv_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        hilo_we;
    logic        hilo_sel;
    logic [31:0] wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    muldiv_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .hilo_we  (hilo_we),
        .hilo_sel (hilo_sel),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
    logic [31:0] p_hi = 32'd0, p_lo = 32'd0;
    int          left = 0;

    task automatic model_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                            output logic [31:0] rh, output logic [31:0] rl);
        longint sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'b00: begin p = {32'd0, x} * {32'd0, y}; rh = p[63:32]; rl = p[31:0]; end
            2'b01: begin p = 64'(sx * sy); rh = p[63:32]; rl = p[31:0]; end
            2'b10: begin
                if (y == 0) begin rh = x; rl = 32'hFFFF_FFFF; end
                else begin rh = x % y; rl = x / y; end
            end
            default: begin
                if (y == 0) begin rh = x; rl = 32'hFFFF_FFFF; end
                else begin
                    q = sx / sy; r = sx % sy;
                    rh = r[31:0]; rl = q[31:0];
                end
            end
        endcase
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_hi = 32'd0; m_lo = 32'd0; left = 0;
        end else if (m_busy) begin
            left--;
            if (left == 0) begin
                m_busy = 1'b0; m_done = 1'b1; m_hi = p_hi; m_lo = p_lo;
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                model_op(op, a, b, p_hi, p_lo);
                left = 33;
                m_busy = 1'b1;
            end else if (hilo_we) begin
                if (hilo_sel) m_hi = wdata;
                else          m_lo = wdata;
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            chk("cyc busy", {63'd0, busy}, {63'd0, m_busy});
            chk("cyc done", {63'd0, done}, {63'd0, m_done});
            chk("cyc hi", {32'd0, hi}, {32'd0, m_hi});
            chk("cyc lo", {32'd0, lo}, {32'd0, m_lo});
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called just after a falling edge; holds start for one rising edge.
    task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input logic [31:0] eh, input logic [31:0] el);
        int waited;
        waited = 40;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                waited = i + 1;
                break;
            end
        end
        chk({name, " done"}, {63'd0, done}, 64'd1);
        chk({name, " latency"}, 64'(waited), 64'd33);
        chk({name, " hi"}, {32'd0, hi}, {32'd0, eh});
        chk({name, " lo"}, {32'd0, lo}, {32'd0, el});
    endtask

    initial begin
        logic [31:0] th, tl;
        rst = 1'b0; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
        hilo_we = 1'b0; hilo_sel = 1'b0; wdata = 32'd0;

        // Pin the model with hand-computed values.
        model_op(2'b01, 32'hFFFF_FFFD, 32'd5, th, tl);
        chk("model mult", {th, tl}, 64'hFFFF_FFFF_FFFF_FFF1);
        model_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, th, tl);
        chk("model div wrap", {th, tl}, 64'h0000_0000_8000_0000);
        model_op(2'b11, 32'hFFFF_FFF9, 32'd2, th, tl);
        chk("model div neg", {th, tl}, 64'hFFFF_FFFF_FFFF_FFFD);

        repeat (2) @(negedge clk);
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset done", {63'd0, done}, 64'd0);
        chk("reset hilo", {hi, lo}, 64'd0);
        rst = 1'b1;

        // MULTU max * max, accepted at the first edge after reset release.
        start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("busy after start", {63'd0, busy}, 64'd1);
        wait_done("multu max", 32'hFFFF_FFFE, 32'h0000_0001);
        @(negedge clk);

        // MULT -3*5, then DIVU 7/2 chained from DONE.
        start_op(2'b01, 32'hFFFF_FFFD, 32'd5);
        wait_done("mult neg", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        start_op(2'b10, 32'd7, 32'd2);
        wait_done("divu chain", 32'd1, 32'd3);
        @(negedge clk);

        start_op(2'b11, 32'hFFFF_FFF9, 32'd2);
        wait_done("div neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        start_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div wrap", 32'd0, 32'h8000_0000);
        start_op(2'b11, 32'h1234_5678, 32'd0);
        wait_done("div by zero", 32'h1234_5678, 32'hFFFF_FFFF);
        start_op(2'b10, 32'd0, 32'd0);
        wait_done("divu 0/0", 32'd0, 32'hFFFF_FFFF);
        start_op(2'b11, 32'h8765_4321, 32'd0);
        wait_done("div neg by zero", 32'h8765_4321, 32'hFFFF_FFFF);
        start_op(2'b01, 32'h8000_0000, 32'h8000_0000);
        wait_done("mult min*min", 32'h4000_0000, 32'd0);
        @(negedge clk);

        // Start and direct write while busy are both ignored.
        start_op(2'b00, 32'd3, 32'd4);
        repeat (3) @(negedge clk);
        start = 1'b1; a = 32'd9; hilo_we = 1'b1; hilo_sel = 1'b0; wdata = 32'hAA;
        @(negedge clk);
        start = 1'b0; hilo_we = 1'b0;
        for (int i = 0; i < 40 && done !== 1'b1; i++) @(negedge clk);
        chk("ignored start hi", {32'd0, hi}, 64'd0);
        chk("ignored start lo", {32'd0, lo}, 64'd12);
        @(negedge clk);
        chk("no second op", {63'd0, busy}, 64'd0);
        hilo_we = 1'b1; hilo_sel = 1'b1; wdata = 32'h55;
        @(negedge clk);
        hilo_we = 1'b0;
        chk("direct hi", {32'd0, hi}, 64'h55);
        chk("direct lo kept", {32'd0, lo}, 64'd12);
        hilo_sel = 1'b0; wdata = 32'h77; hilo_we = 1'b1;
        @(negedge clk);
        hilo_we = 1'b0;
        chk("direct lo", {32'd0, lo}, 64'h77);

        // start wins over simultaneous direct write.
        start = 1'b1; op = 2'b00; a = 32'd6; b = 32'd7; hilo_we = 1'b1; hilo_sel = 1'b1; wdata = 32'h99;
        @(negedge clk);
        start = 1'b0; hilo_we = 1'b0;
        wait_done("start priority", 32'd0, 32'd42);
        @(negedge clk);

        // Asynchronous reset in the middle of CALC.
        start_op(2'b00, 32'd5, 32'd7);
        repeat (10) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async rst busy", {63'd0, busy}, 64'd0);
        chk("async rst done", {63'd0, done}, 64'd0);
        chk("async rst hilo", {hi, lo}, 64'd0);
        repeat (3) @(negedge clk);
        chk("held rst done", {63'd0, done}, 64'd0);
        rst = 1'b1;
        start_op(2'b00, 32'd2, 32'd3);
        wait_done("after reset", 32'd0, 32'd6);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-002 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous active-low reset.
REQ-004 Port start, input, 1 bit: request a new operation, sampled at a rising edge.
REQ-005 Port op, input, 2 bits: operation select, sampled with start.
  - 00 MULTU
  - 01 MULT
  - 10 DIVU
  - 11 DIV
REQ-006 Port a, input, 32 bits: operand A (multiplicand or dividend), sampled with start.
REQ-007 Port b, input, 32 bits: operand B (multiplier or divisor), sampled with start.
REQ-008 Port hilo_we, input, 1 bit: direct write to HI/LO (mthi/mtlo path).
REQ-009 Port hilo_sel, input, 1 bit: direct-write target; 1 = HI, 0 = LO.
REQ-010 Port wdata, input, 32 bits: direct-write data.
REQ-011 Port busy, output, 1 bit: operation in progress; the main controller stalls on mfhi/mflo/mult/div while it is high.
REQ-012 Port done, output, 1 bit: one-cycle pulse; HI/LO hold a new result.
REQ-013 Port hi, output, 32 bits: HI register (product high word or remainder).
REQ-014 Port lo, output, 32 bits: LO register (product low word or quotient).

Function
REQ-015 States SHALL be IDLE, CALC, FIX and DONE; busy = (CALC or FIX); done = DONE.
REQ-016 In IDLE or DONE, start=1 SHALL latch a, b and op, clear the 5-bit iteration counter, and enter CALC at that edge (edge N).
REQ-017 CALC SHALL perform one iteration per cycle on operand magnitudes; signed ops (MULT, DIV) take magnitudes first.
  - MUL: 32-step shift-add into a 64-bit accumulator.
  - DIV: 32-step restoring division.
REQ-018 CALC SHALL exit to FIX at the edge where the counter equals 31 (edge N+32).
REQ-019 FIX SHALL apply sign correction and write HI/LO at edge N+33, then enter DONE; done is high in the cycle following edge N+33.
  - Product sign = sign(a) XOR sign(b).
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
REQ-020 From DONE without start, the FSM SHALL return to IDLE at the next edge; start in DONE SHALL begin a back-to-back operation with no idle cycle.
REQ-021 start while busy=1 SHALL be ignored; the latched operands SHALL NOT change.
REQ-022 hilo_we in IDLE or DONE with start=0 SHALL write wdata to HI (hilo_sel=1) or LO (hilo_sel=0) at that edge.
REQ-023 hilo_we while busy=1, or together with start=1, SHALL be ignored; start has priority.
REQ-024 HI/LO SHALL change only at the FIX exit edge or on an accepted direct write; they hold their values during CALC.
REQ-025 Divide by zero (b=0, DIVU or DIV) SHALL take the full latency and yield hi=a, lo=0xFFFFFFFF, independent of operand signs.
REQ-026 DIV 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0x00000000 (two's-complement wrap, no flag).
REQ-027 The MULT product SHALL be the exact signed 64-bit result; the MULTU product SHALL be the exact unsigned 64-bit result.

Reset
REQ-028 rst=0 SHALL immediately, independent of clk, force IDLE, counter=0, busy=0, done=0, hi=0, lo=0, and clear the internal accumulator and operand registers.
REQ-029 Reset asserted mid-operation SHALL abort it with no HI/LO update.
REQ-030 After rst deasserts, the first rising edge with start=1 SHALL be accepted.

Verification
REQ-031 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF at edge N -> busy high cycles N..N+32, done pulse after edge N+33, hi=0xFFFFFFFE, lo=0x00000001.
REQ-032 MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; then DIVU a=7, b=2 started in DONE -> lo=3, hi=1 at edge N+67 relative to the first start.
REQ-033 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 DIV a=0x12345678, b=0 -> hi=0x12345678, lo=0xFFFFFFFF after full latency; DIVU a=0, b=0 -> hi=0, lo=0xFFFFFFFF.
REQ-035 Start MULTU 3*4, then pulse start with a=9 and hilo_we=1 (wdata=0xAA) at cycle 5 -> result hi=0, lo=12, no second op, no direct write; then hilo_we=1, hilo_sel=1, wdata=0x55 in IDLE -> hi=0x55.
REQ-036 Assert rst=0 between clk edges at cycle 10 of CALC -> busy=0, hi=lo=0 before the next edge, no done pulse; a new MULTU 2*3 after release -> lo=6.
